shuffle_unloader: RTL and testbench

Collects the four 128-bit beats of one shuffle result and reassembles them into one 512-bit word with its nonce. It presents that word to the implode side over the four-phase valid/handshake protocol, and acts as the transmitting end of that protocol. It sits between the shuffle core output and implode, and is the mirror of the explode→shuffle loading path.

---
 rtl/shuffle_unloader_if.sv | 56 +++++
 rtl/shuffle_unloader.sv | 183 ++++++++++++++++++
 tb/tb_shuffle_unloader.sv | 256 +++++++++++++++++++++++++
 3 files changed

// File: rtl/shuffle_unloader_if.sv
// -----------------------------------------------------------------------------
// shuffle_unloader_if
//   Bundles the shuffle-side burst input and the implode-side four-phase
//   request/acknowledge signals of the shuffle unloader.
//
//   Signals (named from the unloader's point of view):
//     i_sh_valid      first beat of a shuffle burst
//     o_sh_ready      unloader can accept a new burst
//     i_sh_data       beat data (explode_width/4 bits)
//     i_nonce         nonce tag, sampled with the first beat
//     o_im_valid      four-phase request towards implode
//     i_im_handshake  four-phase acknowledge from implode (may be asynchronous)
//     o_im_data       reassembled word (explode_width bits)
//     o_nonce         nonce tag of o_im_data
//
//   Modports:
//     slave   the unloader itself (consumes i_*, produces o_*)
//     master  the environment around it (shuffle core + implode)
// -----------------------------------------------------------------------------
interface shuffle_unloader_if #(
  parameter int nonce_width   = 7,
  parameter int explode_width = 512
);

  logic                       i_sh_valid;
  logic                       o_sh_ready;
  logic [explode_width/4-1:0] i_sh_data;
  logic [nonce_width-1:0]     i_nonce;
  logic                       o_im_valid;
  logic                       i_im_handshake;
  logic [explode_width-1:0]   o_im_data;
  logic [nonce_width-1:0]     o_nonce;

  modport slave (
    input  i_sh_valid,
    input  i_sh_data,
    input  i_nonce,
    input  i_im_handshake,
    output o_sh_ready,
    output o_im_valid,
    output o_im_data,
    output o_nonce
  );

  modport master (
    output i_sh_valid,
    output i_sh_data,
    output i_nonce,
    output i_im_handshake,
    input  o_sh_ready,
    input  o_im_valid,
    input  o_im_data,
    input  o_nonce
  );

endinterface : shuffle_unloader_if

// File: rtl/shuffle_unloader.sv
// -----------------------------------------------------------------------------
// shuffle_unloader
//   Collects the four beats of one shuffle result, reassembles them into one
//   explode_width word together with its nonce, and offers that word to the
//   implode side as the transmitting end of a four-phase valid/acknowledge
//   protocol. Mirror image of the explode->shuffle loading path.
//
//   Ports:
//     clk    single clock for the whole block
//     rst_n  asynchronous, active-low reset
//     bus    shuffle_unloader_if.slave
//              shuffle side : i_sh_valid, o_sh_ready, i_sh_data, i_nonce
//              implode side : o_im_valid, i_im_handshake, o_im_data, o_nonce
//
//   Beat k (k = 0..3), H = explode_width/8:
//     i_sh_data[2H-1:H] -> o_im_data[H*k     +: H]
//     i_sh_data[H-1:0]  -> o_im_data[4H+H*k  +: H]
//
//   All outputs are driven straight from flops.
// -----------------------------------------------------------------------------
module shuffle_unloader #(
  parameter int nonce_width   = 7,
  parameter int explode_width = 512,
  parameter int sync_stages   = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  shuffle_unloader_if.slave bus
);

  localparam int beat_width = explode_width / 4;
  localparam int half_width = explode_width / 8;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_BEAT1 = 3'd1,
    ST_BEAT2 = 3'd2,
    ST_BEAT3 = 3'd3,
    ST_REQ   = 3'd4,
    ST_ACK   = 3'd5
  } state_t;

  // Places one beat into the word: the upper half of the beat fills the low
  // half of the word and the lower half of the beat fills the high half.
  function automatic logic [explode_width-1:0] place_beat(
    input logic [explode_width-1:0] word,
    input logic [beat_width-1:0]    beat,
    input logic [1:0]               idx
  );
    logic [explode_width-1:0] result;
    result = word;
    result[half_width*int'(idx) +: half_width] =
      beat[beat_width-1:half_width];
    result[4*half_width + half_width*int'(idx) +: half_width] =
      beat[half_width-1:0];
    return result;
  endfunction

  state_t                   state_q;
  state_t                   state_d;
  logic [sync_stages-1:0]   hs_sync_q;
  logic                     hs_s;
  logic                     ready_q;
  logic                     ready_d;
  logic                     valid_q;
  logic                     valid_d;
  logic [explode_width-1:0] data_q;
  logic [explode_width-1:0] data_d;
  logic [nonce_width-1:0]   nonce_q;
  logic [nonce_width-1:0]   nonce_d;
  logic                     accept_s;
  logic                     beat_we_s;
  logic [1:0]               beat_idx_s;

  // Acknowledge synchronizer: i_im_handshake may come from another clock
  // domain, so only the last stage is ever looked at by the FSM.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hs_sync_q <= '0;
    end else begin
      hs_sync_q <= {hs_sync_q[sync_stages-2:0], bus.i_im_handshake};
    end
  end

  assign hs_s = hs_sync_q[sync_stages-1];

  // FSM next state plus beat write control.
  always_comb begin
    state_d    = state_q;
    accept_s   = 1'b0;
    beat_we_s  = 1'b0;
    beat_idx_s = 2'd0;
    case (state_q)
      ST_IDLE: begin
        // A start pulse while ready is low is dropped without capture.
        if (bus.i_sh_valid && ready_q) begin
          accept_s   = 1'b1;
          beat_we_s  = 1'b1;
          beat_idx_s = 2'd0;
          state_d    = ST_BEAT1;
        end else begin
          state_d    = ST_IDLE;
        end
      end
      // The burst carries no per-beat valid: beats 1..3 follow back to back.
      ST_BEAT1: begin
        beat_we_s  = 1'b1;
        beat_idx_s = 2'd1;
        state_d    = ST_BEAT2;
      end
      ST_BEAT2: begin
        beat_we_s  = 1'b1;
        beat_idx_s = 2'd2;
        state_d    = ST_BEAT3;
      end
      ST_BEAT3: begin
        beat_we_s  = 1'b1;
        beat_idx_s = 2'd3;
        state_d    = ST_REQ;
      end
      ST_REQ: begin
        if (hs_s) begin
          state_d = ST_ACK;
        end else begin
          state_d = ST_REQ;
        end
      end
      // Waiting for the acknowledge to drop keeps a stale high acknowledge
      // from completing the next request.
      ST_ACK: begin
        if (!hs_s) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_ACK;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Next values of the registered outputs. Valid and ready are decoded from
  // the next state so they change on the same edge as the state itself;
  // this also raises ready on the first edge after reset release.
  always_comb begin
    valid_d = (state_d == ST_REQ);
    ready_d = (state_d == ST_IDLE);
    if (beat_we_s) begin
      data_d = place_beat(data_q, bus.i_sh_data, beat_idx_s);
    end else begin
      data_d = data_q;
    end
    if (accept_s) begin
      nonce_d = bus.i_nonce;
    end else begin
      nonce_d = nonce_q;
    end
  end

  // State and output registers; reset drops any in-flight word at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      ready_q <= 1'b0;
      valid_q <= 1'b0;
      data_q  <= '0;
      nonce_q <= '0;
    end else begin
      state_q <= state_d;
      ready_q <= ready_d;
      valid_q <= valid_d;
      data_q  <= data_d;
      nonce_q <= nonce_d;
    end
  end

  assign bus.o_sh_ready = ready_q;
  assign bus.o_im_valid = valid_q;
  assign bus.o_im_data  = data_q;
  assign bus.o_nonce    = nonce_q;

endmodule : shuffle_unloader

// File: tb/tb_shuffle_unloader.sv
// -----------------------------------------------------------------------------
// tb_shuffle_unloader
//   Directed bench for shuffle_unloader. The stimulus side pushes the
//   hand-computed reassembled word of every burst into a scoreboard queue;
//   a monitor pops and compares whenever a new request rises, and also
//   tracks that the word stays stable while the request is up.
// -----------------------------------------------------------------------------
module tb_shuffle_unloader;

  localparam int NW = 7;
  localparam int EW = 512;
  localparam int BW = EW / 4;
  localparam int SS = 2;

  typedef struct packed {
    logic [EW-1:0] data;
    logic [NW-1:0] nonce;
  } exp_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  int checks = 0;
  int errors = 0;
  int rises  = 0;
  exp_t exp_q[$];

  always #5 clk = ~clk;

  shuffle_unloader_if #(.nonce_width(NW), .explode_width(EW)) bus ();

  shuffle_unloader #(
    .nonce_width  (NW),
    .explode_width(EW),
    .sync_stages  (SS)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  task automatic check(input string name, input logic [EW-1:0] act,
                       input logic [EW-1:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: actual %0h required %0h", name, act, req);
    end
  endtask

  // Monitor: compare each new request against the scoreboard.
  initial begin
    logic          prev_valid;
    logic          stable;
    logic [EW-1:0] held_data;
    logic [NW-1:0] held_nonce;
    exp_t          e;
    prev_valid = 1'b0;
    stable     = 1'b1;
    held_data  = '0;
    held_nonce = '0;
    forever begin
      @(negedge clk);
      if (bus.o_im_valid === 1'b1 && !prev_valid) begin
        rises++;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected request: actual word %0h required none",
                   bus.o_im_data);
        end else begin
          e = exp_q.pop_front();
          check("word data", bus.o_im_data, e.data);
          check("word nonce", EW'(bus.o_nonce), EW'(e.nonce));
        end
        held_data  = bus.o_im_data;
        held_nonce = bus.o_nonce;
        stable     = 1'b1;
      end else if (bus.o_im_valid === 1'b1) begin
        if (bus.o_im_data !== held_data || bus.o_nonce !== held_nonce) begin
          stable = 1'b0;
        end
      end else if (prev_valid && rst_n) begin
        check("word stable during request", EW'(stable), EW'(1'b1));
      end
      prev_valid = (bus.o_im_valid === 1'b1);
    end
  end

  // Issues one burst starting at a negedge; returns at the negedge after E3.
  task automatic run_burst(input logic [BW-1:0] b0, input logic [BW-1:0] b1,
                           input logic [BW-1:0] b2, input logic [BW-1:0] b3,
                           input logic [NW-1:0] nonce,
                           input logic [EW-1:0] exp_word);
    exp_t e;
    int   n;
    n = 0;
    while (bus.o_sh_ready !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("ready before burst", EW'(bus.o_sh_ready), EW'(1'b1));
    e.data  = exp_word;
    e.nonce = nonce;
    exp_q.push_back(e);
    bus.i_sh_valid = 1'b1;
    bus.i_sh_data  = b0;
    bus.i_nonce    = nonce;
    @(negedge clk);
    check("ready cleared on accept", EW'(bus.o_sh_ready), EW'(1'b0));
    bus.i_sh_valid = 1'b0;
    bus.i_sh_data  = b1;
    bus.i_nonce    = '0;
    @(negedge clk);
    bus.i_sh_data  = b2;
    @(negedge clk);
    check("no request before E3", EW'(bus.o_im_valid), EW'(1'b0));
    bus.i_sh_data  = b3;
    @(negedge clk);
    check("request after E3", EW'(bus.o_im_valid), EW'(1'b1));
    bus.i_sh_data  = '0;
  endtask

  // Acknowledges the pending request after 'delay' cycles, optionally
  // keeps the acknowledge high for 'hold' extra cycles, then releases it.
  task automatic handshake(input int delay, input int hold);
    int n;
    repeat (delay) @(negedge clk);
    bus.i_im_handshake = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (bus.o_im_valid === 1'b1 && n < 20);
    check("ack rise to valid fall edges", EW'(n), EW'(SS + 1));
    repeat (hold) @(negedge clk);
    if (hold > 0) begin
      check("ready low while stale ack held", EW'(bus.o_sh_ready), EW'(1'b0));
      check("no request while stale ack held", EW'(bus.o_im_valid), EW'(1'b0));
    end
    bus.i_im_handshake = 1'b0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (bus.o_sh_ready !== 1'b1 && n < 20);
    check("ack fall to ready rise edges", EW'(n), EW'(SS + 1));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: actual timeout required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus.i_sh_valid     = 1'b0;
    bus.i_sh_data      = '0;
    bus.i_nonce        = '0;
    bus.i_im_handshake = 1'b0;

    // Reset held with random inputs.
    rst_n = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      bus.i_sh_valid     = 1'($urandom);
      bus.i_sh_data      = {$urandom, $urandom, $urandom, $urandom};
      bus.i_nonce        = NW'($urandom);
      bus.i_im_handshake = 1'($urandom);
    end
    @(negedge clk);
    check("reset ready", EW'(bus.o_sh_ready), EW'(1'b0));
    check("reset valid", EW'(bus.o_im_valid), EW'(1'b0));
    check("reset data", bus.o_im_data, '0);
    check("reset nonce", EW'(bus.o_nonce), '0);
    bus.i_sh_valid     = 1'b0;
    bus.i_sh_data      = '0;
    bus.i_nonce        = '0;
    bus.i_im_handshake = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("ready one edge after release", EW'(bus.o_sh_ready), EW'(1'b1));
    check("valid after release", EW'(bus.o_im_valid), EW'(1'b0));

    // Burst 1: simple repeating halves.
    run_burst(128'h1111111111111111_9999999999999999,
              128'h2222222222222222_AAAAAAAAAAAAAAAA,
              128'h3333333333333333_BBBBBBBBBBBBBBBB,
              128'h4444444444444444_CCCCCCCCCCCCCCCC,
              7'h55,
              512'hCCCCCCCCCCCCCCCC_BBBBBBBBBBBBBBBB_AAAAAAAAAAAAAAAA_9999999999999999_4444444444444444_3333333333333333_2222222222222222_1111111111111111);

    // Start pulse during REQ must be ignored.
    bus.i_sh_valid = 1'b1;
    bus.i_sh_data  = 128'hDEADDEADDEADDEAD_BEEFBEEFBEEFBEEF;
    bus.i_nonce    = 7'h2A;
    @(negedge clk);
    bus.i_sh_valid = 1'b0;
    bus.i_sh_data  = '0;
    bus.i_nonce    = '0;
    @(negedge clk);
    check("ignored start keeps data", bus.o_im_data,
          512'hCCCCCCCCCCCCCCCC_BBBBBBBBBBBBBBBB_AAAAAAAAAAAAAAAA_9999999999999999_4444444444444444_3333333333333333_2222222222222222_1111111111111111);
    check("ignored start keeps nonce", EW'(bus.o_nonce), EW'(7'h55));
    check("ignored start keeps request", EW'(bus.o_im_valid), EW'(1'b1));
    handshake(8, 0);

    // Burst 2: distinct halves, stale acknowledge held across ACK.
    run_burst(128'h0123456789ABCDEF_FEDCBA9876543210,
              128'h0011223344556677_8899AABBCCDDEEFF,
              128'hDEADBEEFCAFEF00D_0F1E2D3C4B5A6978,
              128'h1357924680ACE0BD_A5A55A5AC3C33C3C,
              7'h3A,
              512'hA5A55A5AC3C33C3C_0F1E2D3C4B5A6978_8899AABBCCDDEEFF_FEDCBA9876543210_1357924680ACE0BD_DEADBEEFCAFEF00D_0011223344556677_0123456789ABCDEF);
    handshake(3, 8);

    // Aborted burst: reset between E1 and E2.
    bus.i_sh_valid = 1'b1;
    bus.i_sh_data  = 128'hEEEEEEEEEEEEEEEE_EEEEEEEEEEEEEEEE;
    bus.i_nonce    = 7'h13;
    @(negedge clk);
    bus.i_sh_valid = 1'b0;
    bus.i_sh_data  = 128'hDDDDDDDDDDDDDDDD_DDDDDDDDDDDDDDDD;
    bus.i_nonce    = '0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("async reset ready", EW'(bus.o_sh_ready), EW'(1'b0));
    check("async reset valid", EW'(bus.o_im_valid), EW'(1'b0));
    check("async reset data", bus.o_im_data, '0);
    check("async reset nonce", EW'(bus.o_nonce), '0);
    @(negedge clk);
    bus.i_sh_data = '0;
    rst_n = 1'b1;
    @(negedge clk);
    check("ready after mid-burst reset", EW'(bus.o_sh_ready), EW'(1'b1));

    // Burst 3 after the abort: no residue of the aborted beats.
    run_burst(128'hFFFFFFFF00000000_00000000FFFFFFFF,
              128'h8000000000000001_7FFFFFFFFFFFFFFE,
              128'h0F0F0F0F0F0F0F0F_F0F0F0F0F0F0F0F0,
              128'h5555555555555555_AAAAAAAAAAAAAAAA,
              7'h7F,
              512'hAAAAAAAAAAAAAAAA_F0F0F0F0F0F0F0F0_7FFFFFFFFFFFFFFE_00000000FFFFFFFF_5555555555555555_0F0F0F0F0F0F0F0F_8000000000000001_FFFFFFFF00000000);
    handshake(2, 0);

    repeat (5) @(negedge clk);
    check("request count", EW'(rises), EW'(3));
    check("scoreboard drained", EW'(exp_q.size()), '0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_shuffle_unloader
